// File: rtl/pipe_pkg.sv
// Shared definitions for the decode -> execute pipeline register.
// Default widths match the 16-bit core; wider variants override the
// module parameters and use the flat payload vector built by the top.
package pipe_pkg;

  localparam int unsigned INST_W     = 16;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned ALU_CMD_W  = 3;
  localparam int unsigned REG_ADDR_W = 3;

  // Field order here is the bit order of the flat payload vector (MSB first).
  typedef struct packed {
    logic [INST_W-1:0]     inst;
    logic [DATA_W-1:0]     read1;
    logic [DATA_W-1:0]     read2;
    logic                  wr_en;
    logic [ALU_CMD_W-1:0]  alu_cmd;
    logic [REG_ADDR_W-1:0] write_addr;
  } id_ex_payload_t;

  // Width of the flat payload for an arbitrary set of field widths.
  function automatic int unsigned payload_width(
    input int unsigned inst_w,
    input int unsigned data_w,
    input int unsigned alu_cmd_w,
    input int unsigned reg_addr_w
  );
    return inst_w + 2 * data_w + 1 + alu_cmd_w + reg_addr_w;
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload register with a full flag. Used for the main slot and,
// when the skid buffer is built in, for the skid slot.
// Priority: rst > clear > load > unload. Clear keeps the payload bits so
// downstream outputs stay stable while the slot is empty.
module pipe_skid_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         unload,
  input  logic         clear,
  input  logic [W-1:0] data_in,
  output logic         full,
  output logic [W-1:0] data
);

  // Slot state: reset zeroes everything, load wins over unload.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      data <= data_in;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID -> EX pipeline register with valid/ready handshake and flush.
// Define ID_EX_PIPE_SKID_EN to add a one-entry skid slot; in_ready then
// comes from a flop and has no combinational path from out_ready.
// Without it, in_ready = !out_valid || out_ready.
module id_ex_pipe_reg #(
  parameter int unsigned INST_W     = pipe_pkg::INST_W,
  parameter int unsigned DATA_W     = pipe_pkg::DATA_W,
  parameter int unsigned ALU_CMD_W  = pipe_pkg::ALU_CMD_W,
  parameter int unsigned REG_ADDR_W = pipe_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_W-1:0]     inst,
  input  logic [DATA_W-1:0]     read1,
  input  logic [DATA_W-1:0]     read2,
  input  logic                  wr_en,
  input  logic [ALU_CMD_W-1:0]  alu_cmd,
  input  logic [REG_ADDR_W-1:0] write_addr,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_W-1:0]     inst_out,
  output logic [DATA_W-1:0]     read1_out,
  output logic [DATA_W-1:0]     read2_out,
  output logic                  wr_en_out,
  output logic [ALU_CMD_W-1:0]  alu_cmd_out,
  output logic [REG_ADDR_W-1:0] write_addr_out
);

  import pipe_pkg::*;

  localparam int unsigned PW = payload_width(INST_W, DATA_W, ALU_CMD_W, REG_ADDR_W);

  logic [PW-1:0] in_payload;
  logic [PW-1:0] main_din;
  logic [PW-1:0] main_data;
  logic          main_full;
  logic          main_load;
  logic          xfer_in;
  logic          xfer_out;
  logic          stored_wr_en;

  assign in_payload = {inst, read1, read2, wr_en, alu_cmd, write_addr};
  assign xfer_in    = in_valid && in_ready;
  assign xfer_out   = main_full && out_ready;

`ifdef ID_EX_PIPE_SKID_EN
  logic [PW-1:0] skid_data;
  logic          skid_full;
  logic          skid_load;
  logic          skid_unload;

  // in_ready depends only on the skid flop, never on out_ready.
  assign in_ready = !skid_full;

  // Steering: a full skid refills main on drain (in_ready is low then);
  // otherwise a new beat goes to main if main frees up, else into skid.
  always_comb begin
    main_load   = 1'b0;
    main_din    = in_payload;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    if (skid_full) begin
      main_load   = xfer_out;
      main_din    = skid_data;
      skid_unload = xfer_out;
    end else if (xfer_in) begin
      if (!main_full || out_ready) begin
        main_load = 1'b1;
      end else begin
        skid_load = 1'b1;
      end
    end
  end

  pipe_skid_slot #(.W(PW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .unload  (skid_unload),
    .clear   (flush),
    .data_in (in_payload),
    .full    (skid_full),
    .data    (skid_data)
  );
`else
  assign in_ready  = !main_full || out_ready;
  assign main_load = xfer_in;
  assign main_din  = in_payload;
`endif

  // Flush clears the slot inside pipe_skid_slot, overriding any load.
  pipe_skid_slot #(.W(PW)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (main_load),
    .unload  (xfer_out),
    .clear   (flush),
    .data_in (main_din),
    .full    (main_full),
    .data    (main_data)
  );

  assign {inst_out, read1_out, read2_out, stored_wr_en, alu_cmd_out, write_addr_out} = main_data;

  // A bubble must never write the register file.
  assign wr_en_out = stored_wr_en && main_full;
  assign out_valid = main_full;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg (default widths). Works with or
// without ID_EX_PIPE_SKID_EN; configuration-specific expectations are
// selected with the same macro.
module tb_id_ex_pipe_reg;

  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] inst = '0;
  logic [15:0] read1 = '0;
  logic [15:0] read2 = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  alu_cmd = '0;
  logic [2:0]  write_addr = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] inst_out;
  logic [15:0] read1_out;
  logic [15:0] read2_out;
  logic        wr_en_out;
  logic [2:0]  alu_cmd_out;
  logic [2:0]  write_addr_out;

  id_ex_payload_t drv = '0;
  id_ex_payload_t exp_q[$];
  id_ex_payload_t obs_q[$];
  id_ex_payload_t ref_q[$];
  bit             accepted;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  id_ex_pipe_reg #(
    .INST_W     (16),
    .DATA_W     (16),
    .ALU_CMD_W  (3),
    .REG_ADDR_W (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .inst           (inst),
    .read1          (read1),
    .read2          (read2),
    .wr_en          (wr_en),
    .alu_cmd        (alu_cmd),
    .write_addr     (write_addr),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .inst_out       (inst_out),
    .read1_out      (read1_out),
    .read2_out      (read2_out),
    .wr_en_out      (wr_en_out),
    .alu_cmd_out    (alu_cmd_out),
    .write_addr_out (write_addr_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, run incomplete (%0d/%0d)", pass_cnt, total_cnt);
    $fatal(1);
  end

  // Deterministic payload derived from an instruction word.
  function automatic id_ex_payload_t mk(input logic [15:0] v);
    id_ex_payload_t p;
    logic [15:0] t;
    t            = v * 16'd3;
    p.inst       = v;
    p.read1      = t;
    p.read2      = ~v;
    p.wr_en      = v[0];
    p.alu_cmd    = v[2:0];
    p.write_addr = v[5:3];
    return p;
  endfunction

  function automatic id_ex_payload_t observed();
    id_ex_payload_t p;
    p.inst       = inst_out;
    p.read1      = read1_out;
    p.read2      = read2_out;
    p.wr_en      = wr_en_out;
    p.alu_cmd    = alu_cmd_out;
    p.write_addr = write_addr_out;
    return p;
  endfunction

  task automatic drive(input id_ex_payload_t p, input logic v);
    drv        = p;
    inst       = p.inst;
    read1      = p.read1;
    read2      = p.read2;
    wr_en      = p.wr_en;
    alu_cmd    = p.alu_cmd;
    write_addr = p.write_addr;
    in_valid   = v;
  endtask

  // One clock: sample handshakes before the edge, update the scoreboard.
  task automatic step();
    bit xin, xout, s_rst, s_flush;
    id_ex_payload_t snap, d;
    #1;
    xin     = (in_valid && in_ready) === 1'b1;
    xout    = (out_valid && out_ready) === 1'b1;
    s_rst   = rst;
    s_flush = flush;
    snap    = observed();
    d       = drv;
    @(posedge clk);
    #1;
    accepted = xin;
    if (s_rst) begin
      exp_q.delete();
    end else begin
      if (xout) begin
        obs_q.push_back(snap);
        if (exp_q.size() != 0) ref_q.push_back(exp_q.pop_front());
        else ref_q.push_back('1);
      end
      if (xin && !s_flush) exp_q.push_back(d);
      if (s_flush) exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    flush = 1'b0;
    drive(mk(16'h1234), 1'b1);
    step();
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (observed() !== id_ex_payload_t'('0)) $display("FAIL reset_payload: got %h expected 0", observed());
    else pass_cnt++;
    rst = 1'b0;
    drive(mk(16'h0), 1'b0);
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    id_ex_payload_t p, o, r;
    out_ready = 1'b1;
    for (int unsigned i = 1; i <= 3; i++) begin
      p = mk(i[15:0]);
      drive(p, 1'b1);
      step();
      total_cnt++;
      if (out_valid !== 1'b1 || inst_out !== i[15:0])
        $display("FAIL stream_latency: got valid=%0b inst=%h expected valid=1 inst=%h", out_valid, inst_out, i[15:0]);
      else pass_cnt++;
      total_cnt++;
      if (wr_en_out !== p.wr_en) $display("FAIL stream_wr_en: got %0b expected %0b", wr_en_out, p.wr_en);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL stream_empty: got %0b expected 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (obs_q.size() != 3) $display("FAIL stream_count: got %0d expected 3", obs_q.size());
    else pass_cnt++;
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      r = ref_q.pop_front();
      total_cnt++;
      if (o !== r) $display("FAIL stream_order: got %h expected %h", o, r);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    id_ex_payload_t o, r;
    logic [15:0] cur;
    out_ready = 1'b0;
    cur = 16'd2;
    drive(mk(cur), 1'b1);
    step();
    cur = 16'd3;
    drive(mk(cur), 1'b1);
    #1;
    total_cnt++;
`ifdef ID_EX_PIPE_SKID_EN
    if (in_ready !== 1'b1) $display("FAIL stall_ready_first: got %0b expected 1", in_ready);
`else
    if (in_ready !== 1'b0) $display("FAIL stall_ready_first: got %0b expected 0", in_ready);
`endif
    else pass_cnt++;
    for (int unsigned c = 0; c < 3; c++) begin
      step();
      if (accepted && cur < 16'd4) begin
        cur = cur + 16'd1;
        drive(mk(cur), 1'b1);
      end
      total_cnt++;
      if (out_valid !== 1'b1 || inst_out !== 16'd2)
        $display("FAIL stall_hold: got valid=%0b inst=%h expected valid=1 inst=0002", out_valid, inst_out);
      else pass_cnt++;
      if (c == 0) begin
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL stall_ready_drop: got %0b expected 0", in_ready);
        else pass_cnt++;
      end
    end
    out_ready = 1'b1;
    for (int unsigned c = 0; c < 10; c++) begin
      step();
      if (accepted) begin
        if (cur == 16'd4) in_valid = 1'b0;
        else begin
          cur = cur + 16'd1;
          drive(mk(cur), 1'b1);
        end
      end
    end
    total_cnt++;
    if (obs_q.size() != 3) $display("FAIL stall_count: got %0d expected 3", obs_q.size());
    else pass_cnt++;
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      r = ref_q.pop_front();
      total_cnt++;
      if (o !== r) $display("FAIL stall_order: got %h expected %h", o, r);
      else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    id_ex_payload_t o, r;
    out_ready = 1'b0;
    drive(mk(16'd5), 1'b1);
    step();
    drive(mk(16'd6), 1'b1);
    step();
    drive(mk(16'd9), 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || wr_en_out !== 1'b0)
      $display("FAIL flush_clear: got valid=%0b wr_en=%0b expected 0/0", out_valid, wr_en_out);
    else pass_cnt++;
    out_ready = 1'b1;
    repeat (3) step();
    total_cnt++;
    if (obs_q.size() != 0) $display("FAIL flush_no_emit: got %0d beats expected 0", obs_q.size());
    else pass_cnt++;
    obs_q.delete();
    ref_q.delete();
    // Flush coinciding with a transfer out: the outgoing beat is consumed.
    out_ready = 1'b0;
    drive(mk(16'd7), 1'b1);
    step();
    drive(mk(16'd10), 1'b1);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL flush_consume_empty: got %0b expected 0", out_valid);
    else pass_cnt++;
    repeat (2) step();
    total_cnt++;
    if (obs_q.size() != 1) $display("FAIL flush_consume_count: got %0d expected 1", obs_q.size());
    else pass_cnt++;
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      r = ref_q.pop_front();
      total_cnt++;
      if (o !== r) $display("FAIL flush_consume_beat: got %h expected %h", o, r);
      else pass_cnt++;
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    drive(mk(16'h0fff), 1'b0);
    step();
    step();
    total_cnt++;
    if (out_valid !== 1'b0 || wr_en_out !== 1'b0)
      $display("FAIL bubble: got valid=%0b wr_en=%0b expected 0/0", out_valid, wr_en_out);
    else pass_cnt++;
    total_cnt++;
    if (obs_q.size() != 0) $display("FAIL bubble_emit: got %0d beats expected 0", obs_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b0;
    drive(mk(16'd11), 1'b1);
    step();
    drive(mk(16'd12), 1'b1);
    step();
    drive(mk(16'd13), 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || observed() !== id_ex_payload_t'('0))
      $display("FAIL rst_stall_clear: got valid=%0b payload=%h expected 0/0", out_valid, observed());
    else pass_cnt++;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL rst_stall_ready: got %0b expected 1", in_ready);
    else pass_cnt++;
    out_ready = 1'b1;
    repeat (3) step();
    total_cnt++;
    if (obs_q.size() != 0) $display("FAIL rst_stall_reappear: got %0d beats expected 0", obs_q.size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    id_ex_payload_t o, r, held;
    logic [15:0] cur;
    bit hold;
    cur = 16'd100;
    drive(mk(cur), 1'b1);
    for (int unsigned c = 0; c < 300; c++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      if (!accepted || c == 0) in_valid = ($urandom_range(0, 3) != 0);
      #1;
      hold = (out_valid && !out_ready) === 1'b1;
      held = observed();
      step();
      if (hold) begin
        total_cnt++;
        if (out_valid !== 1'b1 || observed() !== held)
          $display("FAIL b2b_stall_stable: got %h expected %h", observed(), held);
        else pass_cnt++;
      end
      if (accepted) begin
        cur = cur + 16'd1;
        drive(mk(cur), 1'b1);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL b2b_lost: got %0d undelivered beats expected 0", exp_q.size());
    else pass_cnt++;
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      r = ref_q.pop_front();
      total_cnt++;
      if (o !== r) $display("FAIL b2b_order: got %h expected %h", o, r);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_bubble();
    test_reset_stall();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
